// File: rtl/snic_mem_read_arbiter.sv
// snic_mem_read_arbiter: shares one DDR read channel among NUM_REQ requesters.
// Commands are granted round-robin into a single output register. The winner
// index goes into two in-order route FIFOs. Those FIFOs steer returning data
// beats and status words back to the requester that issued each command.
// Optional macro SNIC_MEM_ARB_PERF_EN adds perf_cmd_cnt / perf_stall_cnt.

// In-order route FIFO holding requester indices.
module snic_mem_read_arbiter_route_fifo #(
  parameter int W     = 1,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;

  // Pointer update; the extra MSB separates the full state from the empty state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
endmodule

module snic_mem_read_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int ADDR_WIDTH      = 64,
  parameter int LEN_WIDTH       = 32,
  parameter int DATA_WIDTH      = 512,
  parameter int STS_WIDTH       = 8,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                            net_clk,
  input  logic                            net_aresetn,
  input  logic [NUM_REQ-1:0]              s_cmd_valid,
  output logic [NUM_REQ-1:0]              s_cmd_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   s_cmd_address,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    s_cmd_length,
  output logic                            m_mem_cmd_valid,
  input  logic                            m_mem_cmd_ready,
  output logic [ADDR_WIDTH-1:0]           m_mem_cmd_address,
  output logic [LEN_WIDTH-1:0]            m_mem_cmd_length,
  input  logic                            s_mem_data_valid,
  output logic                            s_mem_data_ready,
  input  logic [DATA_WIDTH-1:0]           s_mem_data_data,
  input  logic [DATA_WIDTH/8-1:0]         s_mem_data_keep,
  input  logic                            s_mem_data_last,
  output logic [NUM_REQ-1:0]              m_data_valid,
  input  logic [NUM_REQ-1:0]              m_data_ready,
  output logic [DATA_WIDTH-1:0]           m_data_data,
  output logic [DATA_WIDTH/8-1:0]         m_data_keep,
  output logic                            m_data_last,
  input  logic                            s_mem_sts_valid,
  output logic                            s_mem_sts_ready,
  input  logic [STS_WIDTH-1:0]            s_mem_sts_data,
  output logic [NUM_REQ-1:0]              m_sts_valid,
  input  logic [NUM_REQ-1:0]              m_sts_ready,
  output logic [STS_WIDTH-1:0]            m_sts_data,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding
`ifdef SNIC_MEM_ARB_PERF_EN
  ,
  output logic [31:0]                     perf_cmd_cnt,
  output logic [31:0]                     perf_stall_cnt
`endif
);
  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int IW1  = IDXW + 1;
  localparam int OW   = $clog2(MAX_OUTSTANDING) + 1;

  logic [IDXW-1:0] rr_ptr;
  logic [IDXW-1:0] gnt_idx;
  logic [IDXW:0]   scan;
  logic            found, can_load, gnt;
  logic [IDXW-1:0] d_head, s_head;
  logic            d_empty, s_empty;
  logic            d_pop, s_pop;

  // The OREG can take a new command when it is empty or draining and the cap is not reached.
  // Status for a command always follows its data, so data_route never holds more than outstanding.
  assign can_load = (!m_mem_cmd_valid || m_mem_cmd_ready) &&
                    (outstanding < OW'(MAX_OUTSTANDING));

  // Round-robin search: the first valid requester at or after rr_ptr wins.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    scan    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, rr_ptr} + IW1'(k);
      if (scan >= IW1'(NUM_REQ)) scan = scan - IW1'(NUM_REQ);
      if (!found && s_cmd_valid[scan[IDXW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = scan[IDXW-1:0];
      end
    end
  end

  assign gnt = found && can_load;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rdy
    assign s_cmd_ready[i] = gnt && (gnt_idx == IDXW'(i));
  end

  // Command register slot and round-robin pointer.
  always_ff @(posedge net_clk) begin
    if (!net_aresetn) begin
      m_mem_cmd_valid   <= 1'b0;
      m_mem_cmd_address <= '0;
      m_mem_cmd_length  <= '0;
      rr_ptr            <= '0;
    end else if (gnt) begin
      m_mem_cmd_valid   <= 1'b1;
      m_mem_cmd_address <= s_cmd_address[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
      m_mem_cmd_length  <= s_cmd_length[gnt_idx*LEN_WIDTH +: LEN_WIDTH];
      rr_ptr            <= (gnt_idx == IDXW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
    end else if (m_mem_cmd_ready) begin
      m_mem_cmd_valid   <= 1'b0;
    end
  end

  // In-flight count: plus one per grant, minus one per status pop.
  always_ff @(posedge net_clk) begin
    if (!net_aresetn) begin
      outstanding <= '0;
    end else begin
      case ({gnt, s_pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  snic_mem_read_arbiter_route_fifo #(.W(IDXW), .DEPTH(MAX_OUTSTANDING)) u_data_route (
    .clk(net_clk), .rst_n(net_aresetn), .push(gnt), .din(gnt_idx),
    .pop(d_pop), .head(d_head), .empty(d_empty)
  );

  snic_mem_read_arbiter_route_fifo #(.W(IDXW), .DEPTH(MAX_OUTSTANDING)) u_sts_route (
    .clk(net_clk), .rst_n(net_aresetn), .push(gnt), .din(gnt_idx),
    .pop(s_pop), .head(s_head), .empty(s_empty)
  );

  // Data steering to the data_route head; with no route entry the channel stalls.
  always_comb begin
    m_data_valid     = '0;
    s_mem_data_ready = 1'b0;
    if (!d_empty) begin
      m_data_valid[d_head] = s_mem_data_valid;
      s_mem_data_ready     = m_data_ready[d_head];
    end
  end

  // Status steering to the sts_route head.
  always_comb begin
    m_sts_valid     = '0;
    s_mem_sts_ready = 1'b0;
    if (!s_empty) begin
      m_sts_valid[s_head] = s_mem_sts_valid;
      s_mem_sts_ready     = m_sts_ready[s_head];
    end
  end

  assign d_pop       = s_mem_data_valid && s_mem_data_ready && s_mem_data_last;
  assign s_pop       = s_mem_sts_valid && s_mem_sts_ready;
  assign m_data_data = s_mem_data_data;
  assign m_data_keep = s_mem_data_keep;
  assign m_data_last = s_mem_data_last;
  assign m_sts_data  = s_mem_sts_data;

`ifdef SNIC_MEM_ARB_PERF_EN
  // Counts command handshakes and the cycles where requests wait without a grant.
  always_ff @(posedge net_clk) begin
    if (!net_aresetn) begin
      perf_cmd_cnt   <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (m_mem_cmd_valid && m_mem_cmd_ready) perf_cmd_cnt <= perf_cmd_cnt + 1'b1;
      if ((|s_cmd_valid) && !gnt)             perf_stall_cnt <= perf_stall_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_snic_mem_read_arbiter.sv
// Directed bench for snic_mem_read_arbiter: a per-cycle vector table plus a
// hand-written full-boundary sequence (and perf counters when enabled).
module tb_snic_mem_read_arbiter;
  localparam int NR = 2, AW = 64, LW = 32, DW = 64, SW = 8, MO = 16;

  logic           net_clk = 1'b0;
  logic           net_aresetn = 1'b0;
  logic [NR-1:0]  s_cmd_valid = '0;
  logic [NR-1:0]  s_cmd_ready;
  logic [NR*AW-1:0] s_cmd_address;
  logic [NR*LW-1:0] s_cmd_length;
  logic           m_mem_cmd_valid;
  logic           m_mem_cmd_ready = 1'b0;
  logic [AW-1:0]  m_mem_cmd_address;
  logic [LW-1:0]  m_mem_cmd_length;
  logic           s_mem_data_valid = 1'b0;
  logic           s_mem_data_ready;
  logic [DW-1:0]  s_mem_data_data = '0;
  logic [DW/8-1:0] s_mem_data_keep = '1;
  logic           s_mem_data_last = 1'b0;
  logic [NR-1:0]  m_data_valid;
  logic [NR-1:0]  m_data_ready = '0;
  logic [DW-1:0]  m_data_data;
  logic [DW/8-1:0] m_data_keep;
  logic           m_data_last;
  logic           s_mem_sts_valid = 1'b0;
  logic           s_mem_sts_ready;
  logic [SW-1:0]  s_mem_sts_data = '0;
  logic [NR-1:0]  m_sts_valid;
  logic [NR-1:0]  m_sts_ready = '0;
  logic [SW-1:0]  m_sts_data;
  logic [$clog2(MO):0] outstanding;
`ifdef SNIC_MEM_ARB_PERF_EN
  logic [31:0] perf_cmd_cnt, perf_stall_cnt;
`endif

  assign s_cmd_address = {64'h1100, 64'h1000};
  assign s_cmd_length  = {32'd128, 32'd64};

  snic_mem_read_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .DATA_WIDTH(DW),
    .STS_WIDTH(SW), .MAX_OUTSTANDING(MO)
  ) dut (
    .net_clk(net_clk), .net_aresetn(net_aresetn),
    .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
    .s_cmd_address(s_cmd_address), .s_cmd_length(s_cmd_length),
    .m_mem_cmd_valid(m_mem_cmd_valid), .m_mem_cmd_ready(m_mem_cmd_ready),
    .m_mem_cmd_address(m_mem_cmd_address), .m_mem_cmd_length(m_mem_cmd_length),
    .s_mem_data_valid(s_mem_data_valid), .s_mem_data_ready(s_mem_data_ready),
    .s_mem_data_data(s_mem_data_data), .s_mem_data_keep(s_mem_data_keep),
    .s_mem_data_last(s_mem_data_last),
    .m_data_valid(m_data_valid), .m_data_ready(m_data_ready),
    .m_data_data(m_data_data), .m_data_keep(m_data_keep), .m_data_last(m_data_last),
    .s_mem_sts_valid(s_mem_sts_valid), .s_mem_sts_ready(s_mem_sts_ready),
    .s_mem_sts_data(s_mem_sts_data),
    .m_sts_valid(m_sts_valid), .m_sts_ready(m_sts_ready), .m_sts_data(m_sts_data),
    .outstanding(outstanding)
`ifdef SNIC_MEM_ARB_PERF_EN
    , .perf_cmd_cnt(perf_cmd_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 net_clk = ~net_clk;

  typedef struct packed {
    logic       rst;
    logic [1:0] cv;
    logic       mrdy;
    logic       dv;
    logic       dl;
    logic [7:0] dd;
    logic [1:0] drdy;
    logic       sv;
    logic [7:0] sd;
    logic [1:0] srdy;
    logic [1:0] e_cr;
    logic       e_mv;
    logic [15:0] e_ma;
    logic [7:0] e_ml;
    logic [1:0] e_dv;
    logic       e_sdr;
    logic [1:0] e_sv;
    logic       e_ssr;
    logic [4:0] e_out;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int row = 0;
  vec_t tbl[$];

  function automatic vec_t v(
    input logic rst, input logic [1:0] cv, input logic mrdy, input logic dv, input logic dl,
    input logic [7:0] dd, input logic [1:0] drdy, input logic sv, input logic [7:0] sd,
    input logic [1:0] srdy, input logic [1:0] e_cr, input logic e_mv, input logic [15:0] e_ma,
    input logic [7:0] e_ml, input logic [1:0] e_dv, input logic e_sdr, input logic [1:0] e_sv,
    input logic e_ssr, input logic [4:0] e_out);
    vec_t t;
    t = '{rst, cv, mrdy, dv, dl, dd, drdy, sv, sd, srdy,
          e_cr, e_mv, e_ma, e_ml, e_dv, e_sdr, e_sv, e_ssr, e_out};
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (row %0d): got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic idle_inputs();
    s_cmd_valid = '0; m_mem_cmd_ready = 1'b1;
    s_mem_data_valid = 1'b0; s_mem_data_last = 1'b0; s_mem_data_data = '0; m_data_ready = '0;
    s_mem_sts_valid = 1'b0; s_mem_sts_data = '0; m_sts_ready = '0;
  endtask

  initial begin
    // rst  cv    mr dv dl dd     drdy   sv sd     srdy  | cr    mv ma        ml   dv     sdr sv     ssr out
    tbl.push_back(v(0, 2'b00, 0, 0, 0, 8'h00, 2'b00, 0, 8'h00, 2'b00, 2'b00, 0, 16'h0,    8'd0,   2'b00, 0, 2'b00, 0, 5'd0));
    tbl.push_back(v(0, 2'b01, 0, 0, 0, 8'h00, 2'b00, 0, 8'h00, 2'b00, 2'b01, 0, 16'h0,    8'd0,   2'b00, 0, 2'b00, 0, 5'd0));
    tbl.push_back(v(0, 2'b00, 0, 0, 0, 8'h00, 2'b00, 0, 8'h00, 2'b00, 2'b00, 1, 16'h1000, 8'd64,  2'b00, 0, 2'b00, 0, 5'd1));
    tbl.push_back(v(0, 2'b00, 1, 0, 0, 8'h00, 2'b00, 0, 8'h00, 2'b00, 2'b00, 1, 16'h1000, 8'd64,  2'b00, 0, 2'b00, 0, 5'd1));
    tbl.push_back(v(0, 2'b10, 1, 0, 0, 8'h00, 2'b00, 0, 8'h00, 2'b00, 2'b10, 0, 16'h0,    8'd0,   2'b00, 0, 2'b00, 0, 5'd1));
    // both requesters held for 6 cycles: grants alternate 0,1,0,1,0,1
    tbl.push_back(v(0, 2'b11, 1, 0, 0, 8'h00, 2'b00, 0, 8'h00, 2'b00, 2'b01, 1, 16'h1100, 8'd128, 2'b00, 0, 2'b00, 0, 5'd2));
    tbl.push_back(v(0, 2'b11, 1, 0, 0, 8'h00, 2'b00, 0, 8'h00, 2'b00, 2'b10, 1, 16'h1000, 8'd64,  2'b00, 0, 2'b00, 0, 5'd3));
    tbl.push_back(v(0, 2'b11, 1, 0, 0, 8'h00, 2'b00, 0, 8'h00, 2'b00, 2'b01, 1, 16'h1100, 8'd128, 2'b00, 0, 2'b00, 0, 5'd4));
    tbl.push_back(v(0, 2'b11, 1, 0, 0, 8'h00, 2'b00, 0, 8'h00, 2'b00, 2'b10, 1, 16'h1000, 8'd64,  2'b00, 0, 2'b00, 0, 5'd5));
    tbl.push_back(v(0, 2'b11, 1, 0, 0, 8'h00, 2'b00, 0, 8'h00, 2'b00, 2'b01, 1, 16'h1100, 8'd128, 2'b00, 0, 2'b00, 0, 5'd6));
    tbl.push_back(v(0, 2'b11, 1, 0, 0, 8'h00, 2'b00, 0, 8'h00, 2'b00, 2'b10, 1, 16'h1000, 8'd64,  2'b00, 0, 2'b00, 0, 5'd7));
    tbl.push_back(v(0, 2'b00, 1, 0, 0, 8'h00, 2'b00, 0, 8'h00, 2'b00, 2'b00, 1, 16'h1100, 8'd128, 2'b00, 0, 2'b00, 0, 5'd8));
    tbl.push_back(v(0, 2'b00, 1, 0, 0, 8'h00, 2'b00, 0, 8'h00, 2'b00, 2'b00, 0, 16'h0,    8'd0,   2'b00, 0, 2'b00, 0, 5'd8));
    // mid-run reset, then reset state
    tbl.push_back(v(1, 2'b00, 1, 0, 0, 8'h00, 2'b00, 0, 8'h00, 2'b00, 2'b00, 0, 16'h0,    8'd0,   2'b00, 0, 2'b00, 0, 5'd8));
    tbl.push_back(v(0, 2'b00, 1, 0, 0, 8'h00, 2'b00, 0, 8'h00, 2'b00, 2'b00, 0, 16'h0,    8'd0,   2'b00, 0, 2'b00, 0, 5'd0));
    // req1 cmd A, req0 cmd B
    tbl.push_back(v(0, 2'b10, 1, 0, 0, 8'h00, 2'b00, 0, 8'h00, 2'b00, 2'b10, 0, 16'h0,    8'd0,   2'b00, 0, 2'b00, 0, 5'd0));
    tbl.push_back(v(0, 2'b01, 1, 0, 0, 8'h00, 2'b00, 0, 8'h00, 2'b00, 2'b01, 1, 16'h1100, 8'd128, 2'b00, 0, 2'b00, 0, 5'd1));
    tbl.push_back(v(0, 2'b00, 1, 0, 0, 8'h00, 2'b00, 0, 8'h00, 2'b00, 2'b00, 1, 16'h1000, 8'd64,  2'b00, 0, 2'b00, 0, 5'd2));
    // beat 1 held by m_data_ready[1]=0, then released; beat 2 last; beat 3 to req0
    tbl.push_back(v(0, 2'b00, 1, 1, 0, 8'hA1, 2'b01, 0, 8'h00, 2'b00, 2'b00, 0, 16'h0,    8'd0,   2'b10, 0, 2'b00, 0, 5'd2));
    tbl.push_back(v(0, 2'b00, 1, 1, 0, 8'hA1, 2'b11, 0, 8'h00, 2'b00, 2'b00, 0, 16'h0,    8'd0,   2'b10, 1, 2'b00, 0, 5'd2));
    tbl.push_back(v(0, 2'b00, 1, 1, 1, 8'hA2, 2'b11, 0, 8'h00, 2'b00, 2'b00, 0, 16'h0,    8'd0,   2'b10, 1, 2'b00, 0, 5'd2));
    tbl.push_back(v(0, 2'b00, 1, 1, 1, 8'hB1, 2'b11, 0, 8'h00, 2'b00, 2'b00, 0, 16'h0,    8'd0,   2'b01, 1, 2'b00, 0, 5'd2));
    // status: held once by m_sts_ready[1]=0, then 1 then 0; data route now empty
    tbl.push_back(v(0, 2'b00, 1, 0, 0, 8'h00, 2'b11, 1, 8'h11, 2'b01, 2'b00, 0, 16'h0,    8'd0,   2'b00, 0, 2'b10, 0, 5'd2));
    tbl.push_back(v(0, 2'b00, 1, 0, 0, 8'h00, 2'b11, 1, 8'h11, 2'b11, 2'b00, 0, 16'h0,    8'd0,   2'b00, 0, 2'b10, 1, 5'd2));
    tbl.push_back(v(0, 2'b00, 1, 0, 0, 8'h00, 2'b11, 1, 8'h22, 2'b11, 2'b00, 0, 16'h0,    8'd0,   2'b00, 0, 2'b01, 1, 5'd1));
    // both routes empty: memory side stalls
    tbl.push_back(v(0, 2'b00, 1, 1, 1, 8'hC3, 2'b11, 1, 8'h33, 2'b11, 2'b00, 0, 16'h0,    8'd0,   2'b00, 0, 2'b00, 0, 5'd0));

    idle_inputs();
    m_mem_cmd_ready = 1'b0;
    net_aresetn = 1'b0;
    repeat (2) @(posedge net_clk);

    foreach (tbl[i]) begin
      vec_t t;
      t = tbl[i];
      row = i;
      @(negedge net_clk);
      net_aresetn = ~t.rst;
      s_cmd_valid = t.cv; m_mem_cmd_ready = t.mrdy;
      s_mem_data_valid = t.dv; s_mem_data_last = t.dl; s_mem_data_data = 64'(t.dd); m_data_ready = t.drdy;
      s_mem_sts_valid = t.sv; s_mem_sts_data = t.sd; m_sts_ready = t.srdy;
      #1;
      chk("s_cmd_ready", 64'(s_cmd_ready), 64'(t.e_cr));
      chk("m_mem_cmd_valid", 64'(m_mem_cmd_valid), 64'(t.e_mv));
      if (t.e_mv) begin
        chk("m_mem_cmd_address", m_mem_cmd_address, 64'(t.e_ma));
        chk("m_mem_cmd_length", 64'(m_mem_cmd_length), 64'(t.e_ml));
      end
      chk("m_data_valid", 64'(m_data_valid), 64'(t.e_dv));
      chk("s_mem_data_ready", 64'(s_mem_data_ready), 64'(t.e_sdr));
      chk("m_data_data", m_data_data, 64'(t.dd));
      chk("m_data_last", 64'(m_data_last), 64'(t.dl));
      chk("m_data_keep", 64'(m_data_keep), 64'hFF);
      chk("m_sts_valid", 64'(m_sts_valid), 64'(t.e_sv));
      chk("s_mem_sts_ready", 64'(s_mem_sts_ready), 64'(t.e_ssr));
      chk("m_sts_data", 64'(m_sts_data), 64'(t.sd));
      chk("outstanding", 64'(outstanding), 64'(t.e_out));
    end

    // Full boundary: 16 grants, blocked while full, status pop does not grant same cycle.
    row = 1000;
    @(negedge net_clk);
    idle_inputs();
    net_aresetn = 1'b0;
    @(negedge net_clk);
    net_aresetn = 1'b1;
    for (int i = 0; i < MO; i++) begin
      row = 1000 + i;
      @(negedge net_clk);
      s_cmd_valid = 2'b01;
      #1;
      chk("full_fill_ready", 64'(s_cmd_ready), 64'h1);
      chk("full_fill_outstanding", 64'(outstanding), 64'(i));
    end
    for (int i = 0; i < 3; i++) begin
      row = 1100 + i;
      @(negedge net_clk);
      #1;
      chk("full_blocked_ready", 64'(s_cmd_ready), 64'h0);
      chk("full_blocked_outstanding", 64'(outstanding), 64'd16);
    end
    row = 1200;
    @(negedge net_clk);
    s_mem_sts_valid = 1'b1; s_mem_sts_data = 8'h5A; m_sts_ready = 2'b11;
    #1;
    chk("full_pop_no_grant", 64'(s_cmd_ready), 64'h0);
    chk("full_pop_sts_ready", 64'(s_mem_sts_ready), 64'h1);
    chk("full_pop_sts_valid", 64'(m_sts_valid), 64'h1);
    row = 1201;
    @(negedge net_clk);
    s_mem_sts_valid = 1'b0; m_sts_ready = 2'b00;
    #1;
    chk("full_resume_grant", 64'(s_cmd_ready), 64'h1);
    chk("full_resume_outstanding", 64'(outstanding), 64'd15);
    row = 1202;
    @(negedge net_clk);
    s_cmd_valid = 2'b00;
    #1;
    chk("full_refill_outstanding", 64'(outstanding), 64'd16);
    chk("full_refill_cmd_valid", 64'(m_mem_cmd_valid), 64'h1);
    row = 1203;
    @(negedge net_clk);
    #1;
    chk("full_drained_cmd_valid", 64'(m_mem_cmd_valid), 64'h0);
`ifdef SNIC_MEM_ARB_PERF_EN
    chk("perf_cmd_cnt", 64'(perf_cmd_cnt), 64'd17);
    chk("perf_stall_cnt", 64'(perf_stall_cnt), 64'd4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
